// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter granting one of three drawing engines exclusive use of the VGA write port.
// The granted requester's pixel stream is registered through to the adapter with one cycle of latency.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  S_IDLE    | no owner; pick the next requester round-robin after 'last'
//  S_GRANT   | requester sel owns the port; pixels forwarded, hold timer runs
//  S_RELEASE | one-cycle gap with no owner; sel recorded as last owner
module vga_write_arbiter #(
    parameter logic [16:0] TIMEOUT = 17'd80000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [2:0]  req,
    input  logic [2:0]  done,
    input  logic [2:0]  we_in,
    input  logic [8:0]  colour_in,
    input  logic [26:0] x_in,
    input  logic [23:0] y_in,
    output logic [2:0]  grant,
    output logic        busy,
    output logic        writeEn,
    output logic [2:0]  colour,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam logic [16:0] HOLD_LAST = TIMEOUT - 17'd1;

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  last_q;
    logic [1:0]  arb_sel;
    logic [16:0] hold_q;
    logic        hold_expired;
    logic        grant_exit;
    logic        cur_req, cur_done, cur_we;
    logic [2:0]  cur_colour;
    logic [8:0]  cur_x;
    logic [7:0]  cur_y;

    // Search upward from the requester after the last owner, wrapping at 2.
    always_comb begin
        arb_sel = 2'd0;
        case (last_q)
            2'd0: begin
                if (req[1])      arb_sel = 2'd1;
                else if (req[2]) arb_sel = 2'd2;
                else             arb_sel = 2'd0;
            end
            2'd1: begin
                if (req[2])      arb_sel = 2'd2;
                else if (req[0]) arb_sel = 2'd0;
                else             arb_sel = 2'd1;
            end
            default: begin
                if (req[0])      arb_sel = 2'd0;
                else if (req[1]) arb_sel = 2'd1;
                else             arb_sel = 2'd2;
            end
        endcase
    end

    // Only the selected requester's lanes are ever visible past this mux.
    always_comb begin
        cur_req    = 1'b0;
        cur_done   = 1'b0;
        cur_we     = 1'b0;
        cur_colour = 3'd0;
        cur_x      = 9'd0;
        cur_y      = 8'd0;
        case (sel_q)
            2'd0: begin
                cur_req    = req[0];
                cur_done   = done[0];
                cur_we     = we_in[0];
                cur_colour = colour_in[2:0];
                cur_x      = x_in[8:0];
                cur_y      = y_in[7:0];
            end
            2'd1: begin
                cur_req    = req[1];
                cur_done   = done[1];
                cur_we     = we_in[1];
                cur_colour = colour_in[5:3];
                cur_x      = x_in[17:9];
                cur_y      = y_in[15:8];
            end
            2'd2: begin
                cur_req    = req[2];
                cur_done   = done[2];
                cur_we     = we_in[2];
                cur_colour = colour_in[8:6];
                cur_x      = x_in[26:18];
                cur_y      = y_in[23:16];
            end
            default: ;
        endcase
    end

    assign hold_expired = (hold_q == HOLD_LAST);
    assign grant_exit   = cur_done | ~cur_req | hold_expired;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (req != 3'b000) begin
                    state_d = S_GRANT;
                    sel_d   = arb_sel;
                end
            end
            S_GRANT: begin
                if (grant_exit) state_d = S_RELEASE;
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant = 3'b000;
        if (state_q == S_GRANT) begin
            case (sel_q)
                2'd0:    grant = 3'b001;
                2'd1:    grant = 3'b010;
                2'd2:    grant = 3'b100;
                default: grant = 3'b000;
            endcase
        end
    end

    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            sel_q       <= 2'd0;
            last_q      <= 2'd2;
            hold_q      <= 17'd0;
            timeout_err <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            if (state_q == S_RELEASE) last_q <= sel_q;
            if (state_q == S_GRANT && !grant_exit) hold_q <= hold_q + 17'd1;
            else                                   hold_q <= 17'd0;
            if (state_q == S_GRANT && hold_expired && !cur_done) timeout_err <= 1'b1;
        end
    end

    // The exit edge clears writeEn so the release cycle never carries a pixel.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            writeEn <= 1'b0;
            colour  <= 3'd0;
            x       <= 9'd0;
            y       <= 8'd0;
        end else if (state_q == S_GRANT && !grant_exit) begin
            writeEn <= cur_we;
            colour  <= cur_colour;
            x       <= cur_x;
            y       <= cur_y;
        end else begin
            writeEn <= 1'b0;
        end
    end

endmodule
